// File: rtl/store_rmw_controller.sv
// Sub-word store sequencer for a word-wide data memory without byte enables.
// Word stores write directly; byte/half stores read, merge lanes, write back.
module store_rmw_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] ST_B = 2'd0;
  localparam logic [1:0] ST_H = 2'd1;
  localparam logic [1:0] ST_W = 2'd2;
  localparam logic [1:0] ST_X = 2'd3;

  // The counter never reaches TIMEOUT itself: the last waiting cycle
  // is the one where it holds TIMEOUT-1.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WRITE,
    S_RESP,
    S_FAULT,
    S_TOUT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] merged_q, merged_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic        accept;
  logic        req_bad;
  logic        waiting;
  logic        expired;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] word_addr;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign word_addr = {addr_q[31:2], 2'b00};
  assign waiting   = (state_q == S_RD_REQ) ||
                     (state_q == S_RD_WAIT) ||
                     (state_q == S_WRITE);
  assign expired   = (cnt_q == CNT_LAST);

  // Alignment / legality check on the incoming request.
  always_comb begin
    req_bad = 1'b0;
    unique case (1'b1)
      (req_type == ST_X): req_bad = 1'b1;
      (req_type == ST_H): req_bad = req_addr[0];
      (req_type == ST_W): req_bad = |req_addr[1:0];
      default:            req_bad = 1'b0;
    endcase
  end

  // Lane mask and replicated lane data from the latched request.
  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    lane_data = data_q;
    unique case (type_q)
      ST_B: begin
        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        lane_data = {4{data_q[7:0]}};
      end
      ST_H: begin
        lane_mask = 32'h0000_FFFF << {addr_q[1:0], 3'b000};
        lane_data = {2{data_q[15:0]}};
      end
      default: begin
        lane_mask = 32'hFFFF_FFFF;
        lane_data = data_q;
      end
    endcase
  end

  // Next-state, request latching and merge register.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    addr_d   = addr_q;
    data_d   = data_q;
    merged_d = merged_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d = req_type;
          addr_d = req_addr;
          data_d = req_data;
          if (req_bad) begin
            state_d = S_FAULT;
          end else if (req_type == ST_W) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_gnt) begin
          state_d = S_RD_WAIT;
        end else if (expired) begin
          state_d = S_TOUT;
        end
      end
      S_RD_WAIT: begin
        if (mem_rvalid) begin
          merged_d = (mem_rdata & ~lane_mask) |
                     (lane_data & lane_mask);
          state_d  = S_WRITE;
        end else if (expired) begin
          state_d = S_TOUT;
        end
      end
      S_WRITE: begin
        if (mem_gnt) begin
          state_d = S_RESP;
        end else if (expired) begin
          state_d = S_TOUT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      S_TOUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change.
  always_comb begin
    cnt_d = 16'd0;
    if ((state_d == state_q) && waiting) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Completion flags follow the next state so they are registered.
  always_comb begin
    done_d = (state_d == S_RESP) ||
             (state_d == S_FAULT) ||
             (state_d == S_TOUT);
    mis_d  = (state_d == S_FAULT);
    berr_d = (state_d == S_TOUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      type_q   <= 2'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      merged_q <= 32'd0;
      cnt_q    <= 16'd0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      merged_q <= merged_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  // Memory port and handshake outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_req   = (state_q == S_RD_REQ) || (state_q == S_WRITE);
    mem_we    = (state_q == S_WRITE);
    mem_addr  = mem_req ? word_addr : 32'd0;
    mem_wdata = 32'd0;
    if (state_q == S_WRITE) begin
      mem_wdata = (type_q == ST_W) ? data_q : merged_q;
    end
  end

  assign done       = done_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_store_rmw_controller.sv
// Randomized bench for store_rmw_controller with a byte-level
// memory reference model and a stalling memory responder.
module tb_store_rmw_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        done;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail = 0;

  // responder knobs and statistics
  int gstall = 0;
  int rvlat = 1;
  bit rv_never = 0;
  bit junk = 0;
  int n_rd = 0, n_wr = 0, n_done = 0, req_cyc = 0;
  int stab_err = 0, align_err = 0, flag_err = 0;
  logic [31:0] last_raddr = 0, last_waddr = 0, last_wdata = 0;

  logic [31:0] mem_act [int unsigned];
  logic [7:0]  ref_b [int unsigned];

  always #5 clk = ~clk;

  store_rmw_controller #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
    .done(done), .misaligned(misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // memory responder: grants after gstall cycles, read data rvlat later
  initial begin
    int sc;
    int rcnt;
    bit pr;
    logic [31:0] pend, pa, pwd;
    logic pwe;
    sc = 0; rcnt = 0; pr = 0; pend = 0; pa = 0; pwd = 0; pwe = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = $urandom;
      if (done) n_done++;
      if ((misaligned || bus_error) && !done) flag_err++;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rvalid = 1;
          mem_rdata = pend;
        end
      end else if (junk && !rv_never && $urandom_range(0, 2) == 0) begin
        mem_rvalid = 1;
      end
      if (mem_req) begin
        req_cyc++;
        if (mem_addr[1:0] != 2'b00) align_err++;
        if (pr && (mem_addr !== pa || mem_we !== pwe ||
                   (mem_we && mem_wdata !== pwd))) stab_err++;
        pr = 1; pa = mem_addr; pwe = mem_we; pwd = mem_wdata;
        if (sc < gstall) begin
          sc++;
        end else begin
          mem_gnt = 1;
          sc = 0;
          pr = 0;
          if (mem_we) begin
            n_wr++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
            mem_act[mem_addr] = mem_wdata;
          end else begin
            n_rd++;
            last_raddr = mem_addr;
            if (!rv_never) begin
              rcnt = rvlat;
              pend = mem_act.exists(mem_addr) ? mem_act[mem_addr] : 32'd0;
            end
          end
        end
      end else begin
        sc = 0;
        pr = 0;
      end
    end
  end

  // reference model helpers
  function automatic logic exp_mis(input logic [1:0] t, input logic [31:0] a);
    return (t == 2'd3) || (t == 2'd1 && a[0]) ||
           (t == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  task automatic set_word(input logic [31:0] wa, input logic [31:0] v);
    mem_act[wa] = v;
    for (int i = 0; i < 4; i++) ref_b[wa + i] = v[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    logic [31:0] r;
    int unsigned k;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      k = wa + i;
      r[8*i +: 8] = ref_b.exists(k) ? ref_b[k] : 8'h00;
    end
    return r;
  endfunction

  function automatic logic [31:0] act_word(input logic [31:0] wa);
    return mem_act.exists(wa) ? mem_act[wa] : 32'hxxxx_xxxx;
  endfunction

  task automatic ref_store(input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d);
    for (int i = 0; i < nbytes(t); i++) ref_b[a + i] = d[8*i +: 8];
  endtask

  // issue one request from a negedge; returns at the negedge after done
  task automatic do_store(input logic [1:0] t, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic mis, output logic be,
                          output logic rdy_ok, output logic one_pulse);
    req_type = t; req_addr = a; req_data = d; req_valid = 1;
    rdy_ok = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    req_type = 2'($urandom);
    req_addr = $urandom;
    req_data = $urandom;
    lat = -1; mis = 0; be = 0; one_pulse = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c; mis = misaligned; be = bus_error;
        if (req_ready) rdy_ok = 0;
        break;
      end
      @(negedge clk);
    end
    if (lat > 0) begin
      @(negedge clk);
      one_pulse = !done;
      if (!req_ready) rdy_ok = 0;
    end
  endtask

  task automatic test_reset;
    int w0, d0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, mem_req, mem_we, done, misaligned, bus_error} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/req/we/done/mis/berr=%b want 100000",
               {req_ready, mem_req, mem_we, done, misaligned, bus_error});
    end
    n_checks++;
    if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    rst_n = 1;
    @(negedge clk);
    gstall = 20;
    set_word(32'h300, 32'h0102_0304);
    req_type = 2'd0; req_addr = 32'h301; req_data = 32'h77; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_req: got mem_req=%b want 1", mem_req);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got rdy=%b req=%b done=%b want 1 0 0",
               req_ready, mem_req, done);
    end
    w0 = n_wr; d0 = n_done;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_wr != w0 || n_done != d0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abandon: got writes=%0d dones=%0d rdy=%b want %0d %0d 1",
               n_wr - w0, n_done - d0, req_ready, 0, 0);
    end
    gstall = 0;
  endtask

  task automatic test_halfword;
    int lat, r0, w0;
    logic mis, be, rok, op;
    gstall = 0; rvlat = 1;
    set_word(32'h100, 32'h1122_3344);
    r0 = n_rd; w0 = n_wr;
    do_store(2'd1, 32'h102, 32'hAAAA_BEEF, lat, mis, be, rok, op);
    ref_store(2'd1, 32'h102, 32'hAAAA_BEEF);
    n_checks++;
    if (lat != 4 || mis !== 0 || be !== 0) begin
      n_fail++;
      $display("FAIL half_timing: got lat=%0d mis=%b berr=%b want 4 0 0", lat, mis, be);
    end
    n_checks++;
    if (n_rd - r0 != 1 || last_raddr !== 32'h100) begin
      n_fail++;
      $display("FAIL half_read: got reads=%0d addr=%h want 1 00000100",
               n_rd - r0, last_raddr);
    end
    n_checks++;
    if (n_wr - w0 != 1 || last_waddr !== 32'h100 || last_wdata !== 32'hBEEF_3344) begin
      n_fail++;
      $display("FAIL half_write: got n=%0d addr=%h data=%h want 1 00000100 beef3344",
               n_wr - w0, last_waddr, last_wdata);
    end
    n_checks++;
    if (rok !== 1 || op !== 1) begin
      n_fail++;
      $display("FAIL half_handshake: got ready_ok=%b single_done=%b want 1 1", rok, op);
    end
  endtask

  task automatic test_byte;
    int lat;
    logic mis, be, rok, op;
    set_word(32'h200, 32'hFFFF_FFFF);
    do_store(2'd0, 32'h203, 32'h0000_0055, lat, mis, be, rok, op);
    ref_store(2'd0, 32'h203, 32'h0000_0055);
    n_checks++;
    if (last_waddr !== 32'h200 || last_wdata !== 32'h55FF_FFFF || lat != 4) begin
      n_fail++;
      $display("FAIL byte_write: got addr=%h data=%h lat=%0d want 00000200 55ffffff 4",
               last_waddr, last_wdata, lat);
    end
  endtask

  task automatic test_word_stall;
    int lat, r0, w0, c0, s0;
    logic mis, be, rok, op;
    gstall = 3;
    r0 = n_rd; w0 = n_wr; c0 = req_cyc; s0 = stab_err;
    do_store(2'd2, 32'h40, 32'hDEAD_BEEF, lat, mis, be, rok, op);
    ref_store(2'd2, 32'h40, 32'hDEAD_BEEF);
    n_checks++;
    if (req_cyc - c0 != 4 || stab_err != s0) begin
      n_fail++;
      $display("FAIL word_stall_req: got req_cycles=%0d unstable=%0d want 4 0",
               req_cyc - c0, stab_err - s0);
    end
    n_checks++;
    if (n_rd != r0 || n_wr - w0 != 1 || last_wdata !== 32'hDEAD_BEEF ||
        last_waddr !== 32'h40) begin
      n_fail++;
      $display("FAIL word_stall_bus: got reads=%0d writes=%0d addr=%h data=%h want 0 1 00000040 deadbeef",
               n_rd - r0, n_wr - w0, last_waddr, last_wdata);
    end
    n_checks++;
    if (lat != 5 || be !== 0 || mis !== 0) begin
      n_fail++;
      $display("FAIL word_stall_done: got lat=%0d berr=%b mis=%b want 5 0 0", lat, be, mis);
    end
    gstall = 0;
  endtask

  task automatic test_misalign;
    logic [1:0]  ts [3];
    logic [31:0] as [3];
    int lat, c0;
    logic mis, be, rok, op;
    ts[0] = 2'd2; as[0] = 32'h41;
    ts[1] = 2'd1; as[1] = 32'h43;
    ts[2] = 2'd3; as[2] = 32'h80;
    for (int i = 0; i < 3; i++) begin
      c0 = req_cyc;
      do_store(ts[i], as[i], $urandom, lat, mis, be, rok, op);
      n_checks++;
      if (lat != 1 || mis !== 1 || be !== 0 || req_cyc != c0 || op !== 1) begin
        n_fail++;
        $display("FAIL misalign_%0d: got lat=%0d mis=%b berr=%b req_cycles=%0d want 1 1 0 0",
                 i, lat, mis, be, req_cyc - c0);
      end
    end
  endtask

  task automatic test_timeout;
    int lat, w0;
    logic mis, be, rok, op;
    gstall = 0; rv_never = 1;
    w0 = n_wr;
    do_store(2'd0, 32'h500, 32'h12, lat, mis, be, rok, op);
    rv_never = 0;
    n_checks++;
    if (lat != 6 || be !== 1 || mis !== 0 || n_wr != w0) begin
      n_fail++;
      $display("FAIL timeout_rvalid: got lat=%0d berr=%b mis=%b writes=%0d want 6 1 0 0",
               lat, be, mis, n_wr - w0);
    end
    gstall = 4;
    w0 = n_wr;
    do_store(2'd2, 32'h504, 32'h9999_0000, lat, mis, be, rok, op);
    gstall = 0;
    n_checks++;
    if (lat != 5 || be !== 1 || n_wr != w0) begin
      n_fail++;
      $display("FAIL timeout_grant: got lat=%0d berr=%b writes=%0d want 5 1 0",
               lat, be, n_wr - w0);
    end
    set_word(32'h600, 32'h0);
    do_store(2'd0, 32'h601, 32'hA5, lat, mis, be, rok, op);
    ref_store(2'd0, 32'h601, 32'hA5);
    n_checks++;
    if (lat != 4 || be !== 0 || last_wdata !== 32'h0000_A500 || rok !== 1) begin
      n_fail++;
      $display("FAIL timeout_recover: got lat=%0d berr=%b data=%h rdy=%b want 4 0 0000a500 1",
               lat, be, last_wdata, rok);
    end
    rvlat = 4;
    set_word(32'h608, 32'h8765_4321);
    do_store(2'd1, 32'h608, 32'h1234_CAFE, lat, mis, be, rok, op);
    ref_store(2'd1, 32'h608, 32'h1234_CAFE);
    rvlat = 1;
    n_checks++;
    if (lat != 7 || be !== 0 || last_wdata !== ref_word(32'h608)) begin
      n_fail++;
      $display("FAIL timeout_edge_rvalid: got lat=%0d berr=%b data=%h want 7 0 %h",
               lat, be, last_wdata, ref_word(32'h608));
    end
  endtask

  task automatic test_back_to_back;
    int d0, w0;
    gstall = 0;
    d0 = n_done; w0 = n_wr;
    req_type = 2'd2; req_addr = 32'h700; req_data = 32'h0BAD_F00D; req_valid = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    repeat (4) @(negedge clk);
    ref_store(2'd2, 32'h700, 32'h0BAD_F00D);
    n_checks++;
    if (n_done - d0 != 2 || n_wr - w0 != 2) begin
      n_fail++;
      $display("FAIL back_to_back: got dones=%0d writes=%0d want 2 2",
               n_done - d0, n_wr - w0);
    end
    n_checks++;
    if (act_word(32'h700) !== ref_word(32'h700)) begin
      n_fail++;
      $display("FAIL b2b_mem: got %h want %h", act_word(32'h700), ref_word(32'h700));
    end
  endtask

  task automatic test_random;
    int lat, el, r0, w0;
    logic mis, be, rok, op, em;
    logic [1:0] t;
    logic [31:0] a, d, wa;
    junk = 1;
    for (int it = 0; it < 60; it++) begin
      t = 2'($urandom_range(0, 3));
      a = 32'h1000 + 32'($urandom_range(0, 63));
      d = $urandom;
      gstall = $urandom_range(0, 3);
      rvlat = $urandom_range(1, 4);
      em = exp_mis(t, a);
      el = em ? 1 : (t == 2'd2) ? 2 + gstall : 3 + 2 * gstall + rvlat;
      wa = {a[31:2], 2'b00};
      r0 = n_rd; w0 = n_wr;
      do_store(t, a, d, lat, mis, be, rok, op);
      n_checks++;
      if (lat != el || mis !== em || be !== 0 || rok !== 1 || op !== 1) begin
        n_fail++;
        $display("FAIL rand_%0d_resp: t=%0d a=%h got lat=%0d mis=%b berr=%b rdy=%b one=%b want %0d %b 0 1 1",
                 it, t, a, lat, mis, be, rok, op, el, em);
      end
      if (!em) begin
        ref_store(t, a, d);
        n_checks++;
        if (act_word(wa) !== ref_word(wa) || n_wr - w0 != 1 ||
            n_rd - r0 != ((t == 2'd2) ? 0 : 1)) begin
          n_fail++;
          $display("FAIL rand_%0d_mem: t=%0d a=%h got word=%h rd=%0d wr=%0d want %h",
                   it, t, a, act_word(wa), n_rd - r0, n_wr - w0, ref_word(wa));
        end
      end
    end
    junk = 0;
    gstall = 0;
    rvlat = 1;
    n_checks++;
    if (stab_err != 0 || align_err != 0 || flag_err != 0) begin
      n_fail++;
      $display("FAIL bus_rules: got unstable=%0d unaligned=%0d lone_flag=%0d want 0 0 0",
               stab_err, align_err, flag_err);
    end
  endtask

  initial begin
    rst_n = 0;
    req_valid = 0; req_type = 0; req_addr = 0; req_data = 0;
    test_reset;
    test_halfword;
    test_byte;
    test_word_stall;
    test_misalign;
    test_timeout;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
